// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   DATA_WIDTH : default instruction / PC width
//   RESET_PC   : default first fetch address after reset
//   NOP_INSTR  : addi x0,x0,0, the bubble instruction placed in IF/ID
//   fetch_state_t : fetch controller states
package riscv_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET,    // one idle cycle after reset before the first request
    S_FETCH,    // request outstanding at imem_addr
    S_DISCARD,  // waiting for a response that a redirect made stale
    S_HOLD      // response captured in the skid buffer while decode stalls
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture instr_next / pc_next / pc_plus4_next as a valid entry
//   bubble          : replace the entry with a NOP (valid=0); wins over load
//   instr/pc/pc_plus4/valid : register contents presented to decode
// With neither load nor bubble the entry holds (decode stall).
module if_id_reg #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [DATA_WIDTH-1:0] instr_next,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic [DATA_WIDTH-1:0] pc_plus4_next,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  valid
);

  // Bubbles leave pc/pc_plus4 untouched; decode ignores them when valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_next;
      pc       <= pc_next;
      pc_plus4 <= pc_plus4_next;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding requests to
// instruction memory and loads the IF/ID register.
//   clk, rst               : clock, synchronous active-high reset
//   StallD                 : hold IF/ID and PC
//   PCSrcE, PCE, ImmOpE    : taken branch redirect to PCE + (ImmOpE << 1), flushes IF/ID
//   imem_req, imem_addr    : level request held until imem_rvalid, word-aligned address
//   imem_rvalid, imem_rdata: response strobe and instruction word
//   instrD, PCD, PCPlus4D, validD : IF/ID contents
module fetch_stage #(
  parameter int unsigned           DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(riscv_pkg::RESET_PC),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(riscv_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] ImmOpE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  validD
);

  import riscv_pkg::fetch_state_t;
  import riscv_pkg::S_RESET;
  import riscv_pkg::S_FETCH;
  import riscv_pkg::S_DISCARD;
  import riscv_pkg::S_HOLD;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  req_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  ifid_load;
  logic                  ifid_bubble;
  logic [DATA_WIDTH-1:0] ifid_instr;

  // Sequential PC and branch target; the target is forced word-aligned.
  assign pc_plus4      = pc_q + DATA_WIDTH'(4);
  assign branch_target = (PCE + (ImmOpE << 1)) & ~DATA_WIDTH'(3);

  // State, PC and skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      req_q   <= (state_d == S_FETCH);
    end
  end

  // Next-state, PC update and IF/ID control. A redirect always bubbles IF/ID,
  // even under StallD; the PC only moves on a consumed response or redirect,
  // so imem_addr stays stable while a request is outstanding.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_d      = skid_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata;

    case (state_q)
      S_RESET: begin
        state_d     = S_FETCH;
        ifid_bubble = PCSrcE | ~StallD;
        if (PCSrcE) pc_d = branch_target;
      end

      S_FETCH: begin
        if (PCSrcE) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
          // Without a response the request is still in flight and its data is stale.
          if (!imem_rvalid) state_d = S_DISCARD;
        end else if (imem_rvalid) begin
          if (StallD) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end
        end else begin
          ifid_bubble = ~StallD;
        end
      end

      S_DISCARD: begin
        ifid_bubble = PCSrcE | ~StallD;
        if (PCSrcE)      pc_d    = branch_target;
        if (imem_rvalid) state_d = S_FETCH;
      end

      S_HOLD: begin
        ifid_instr = skid_q;
        if (PCSrcE) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
          state_d     = S_FETCH;
        end else if (!StallD) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = S_FETCH;
        end
      end

      default: state_d = S_RESET;
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  // IF/ID register.
  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk           (clk),
    .rst           (rst),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .instr_next    (ifid_instr),
    .pc_next       (pc_q),
    .pc_plus4_next (pc_plus4),
    .instr         (instrD),
    .pc            (PCD),
    .pc_plus4      (PCPlus4D),
    .valid         (validD)
  );

endmodule
